// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on both sides.
// Single-cycle ops complete on the accept edge. MUL is a shift-and-add
// sequencer taking XLEN cycles.
// Multiplier support is built only when ALU_SEQ_MUL_EN is defined.
// Without it, opcode 1010 decodes as illegal, busy is tied low and no
// multiplier state exists.

module alu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_out,
    output logic            zero,
    output logic            illegal_op,
    output logic            busy
);

    localparam int SHAMT_W = $clog2(XLEN);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1010;
`endif

    // Output holding registers
    logic            r_out_valid;
    logic [XLEN-1:0] r_alu_out;
    logic            r_zero;
    logic            r_illegal;

    // Combinational single-cycle datapath and handshake
    logic [XLEN-1:0] w_result;
    logic            w_illegal;
    logic            w_is_mul;
    logic [SHAMT_W-1:0] w_shamt;
    logic            w_slt;
    logic            w_sltu;
    logic            w_accept;
    logic            w_busy;

    // Multiplier control/result seen by the output register
    logic            w_mul_start;
    logic            w_mul_done;
    logic [XLEN-1:0] w_mul_result;

    assign w_shamt = op2[SHAMT_W-1:0];
    assign w_slt   = $signed(op1) < $signed(op2);
    assign w_sltu  = op1 < op2;

    // Single-cycle result and opcode legality decode
    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        w_is_mul  = 1'b0;
        case (alu_op)
            OP_AND:  w_result = op1 & op2;
            OP_OR:   w_result = op1 | op2;
            OP_ADD:  w_result = op1 + op2;
            OP_XOR:  w_result = op1 ^ op2;
            OP_SLL:  w_result = op1 << w_shamt;
            OP_SRL:  w_result = op1 >> w_shamt;
            OP_SUB:  w_result = op1 - op2;
            OP_SRA:  w_result = $signed(op1) >>> w_shamt;
            OP_SLT:  w_result = {{(XLEN-1){1'b0}}, w_slt};
            OP_SLTU: w_result = {{(XLEN-1){1'b0}}, w_sltu};
`ifdef ALU_SEQ_MUL_EN
            OP_MUL:  w_is_mul = 1'b1;
`endif
            default: begin
                w_result  = '0;
                w_illegal = 1'b1;
            end
        endcase
    end

    // A held result blocks new requests until the consumer takes it;
    // reset forces in_ready low regardless of register state.
    assign in_ready = rst_n && !w_busy && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [XLEN-1:0]    r_acc;
    logic [XLEN-1:0]    r_mcand;
    logic [XLEN-1:0]    r_mplier;
    logic [SHAMT_W-1:0] r_cnt;
    logic [XLEN-1:0]    w_acc_next;

    assign w_busy       = (r_state == ST_MUL);
    assign w_acc_next   = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_result = w_acc_next;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state; start on a MUL accept, finish on the last partial product
    always_comb begin
        w_state_next = r_state;
        w_mul_start  = 1'b0;
        w_mul_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_mul_start  = 1'b1;
                    w_state_next = ST_MUL;
                end
            end
            ST_MUL: begin
                if (r_cnt == SHAMT_W'(XLEN-1)) begin
                    w_mul_done   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Shift-and-add multiplier datapath, operands captured on the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (w_mul_start) begin
            r_acc    <= '0;
            r_mcand  <= op1;
            r_mplier <= op2;
            r_cnt    <= '0;
        end else if (r_state == ST_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end
`else
    assign w_busy       = 1'b0;
    assign w_mul_start  = 1'b0;
    assign w_mul_done   = 1'b0;
    assign w_mul_result = '0;
`endif

    // Result/flag register. Completion of a MUL and a new accept cannot
    // coincide because busy holds in_ready low during MUL. A MUL accept
    // drops out_valid until the product is ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_alu_out   <= '0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_mul_done) begin
            r_out_valid <= 1'b1;
            r_alu_out   <= w_mul_result;
            r_zero      <= (w_mul_result == '0);
            r_illegal   <= 1'b0;
        end else if (w_accept) begin
            if (w_is_mul || w_mul_start) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= 1'b1;
                r_alu_out   <= w_result;
                r_zero      <= (w_result == '0);
                r_illegal   <= w_illegal;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign alu_out    = r_alu_out;
    assign zero       = r_zero;
    assign illegal_op = r_illegal;
    assign busy       = w_busy;

endmodule
